tri_draw_scheduler: RTL and testbench
=====================================

Name: tri_draw_scheduler

Overview:
- Queues triangle draw commands from two independent requesters (e.g. host command port and overlay engine) in per-port FIFOs.
- Arbitrates between the ports round-robin.
- Sequences the shared triangle_rasterizer: load vertices/colour, pulse start, wait for done.
- Forwards rasterizer pixel output to the framebuffer write port and reports per-command completion and pixel counts.

Parameters:
- FIFO_DEPTH, 4, command entries per requester port; power of two, min 2.
- CNT_W, 16, width of the per-command pixel counter.
- SCREEN_W, 160, framebuffer width in pixels; used only with FB_CLIP_EN.
- SCREEN_H, 120, framebuffer height in pixels; used only with FB_CLIP_EN.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req0_valid  in  1  port 0 command valid.
- req0_ready  out  1  port 0 FIFO not full.
- req0_cmd  in  72  port 0 command {color[23:0], y2, x2, y1, x1, y0, x0}; 8 bits per coordinate.
- req1_valid, req1_ready, req1_cmd  same as port 0, for port 1.
- rast_start  out  1  one-cycle start pulse to the rasterizer.
- rast_vtx  out  48  {y2, x2, y1, x1, y0, x0} to the rasterizer.
- rast_color  out  24  colour to the rasterizer.
- rast_pixel_valid  in  1  rasterizer pixel strobe.
- rast_px, rast_py  in  8  rasterizer pixel coordinates.
- rast_pixel_color  in  24  rasterizer pixel colour.
- rast_done  in  1  rasterizer finished; cleared by the rasterizer on start.
- fb_we  out  1  framebuffer write enable.
- fb_x, fb_y  out  8  framebuffer write address.
- fb_color  out  24  framebuffer write data.
- busy  out  1  high in any state except IDLE.
- cur_src  out  1  port index of the command in flight.
- cmd_done  out  1  one-cycle pulse when a command retires.
- done_src  out  1  port of the retiring command; valid with cmd_done.
- pixel_count  out  CNT_W  pixels written for the current/last command.

Behaviour:
- Reset (async assert, sync release):
  - both FIFOs emptied; FSM to IDLE; round-robin pointer set to port 0.
  - all outputs 0, except req*_ready = 1 after reset.
  - reset mid-command discards the in-flight command and all queued commands.
- FIFOs:
  - push on req_valid & req_ready; req_ready = !full, a registered full flag.
  - wrap-around pointers with an extra MSB for full/empty detection.
  - a push into a full FIFO cannot occur: ready is low.
  - simultaneous push and pop on the same FIFO is allowed; occupancy is unchanged.
- Arbiter (evaluated only in IDLE):
  - if one FIFO is non-empty, grant it.
  - if both are non-empty, grant the port named by the pointer.
  - after each grant the pointer moves to the other port.
- FSM:
  - IDLE: on any non-empty FIFO, pop the granted entry; latch rast_vtx, rast_color and cur_src; clear pixel_count; go to START.
  - START: rast_start = 1 for exactly this cycle; rast_done is ignored; go to WAIT.
  - WAIT: stay until rast_done = 1, then go to RETIRE.
  - RETIRE: cmd_done = 1 and done_src = cur_src for one cycle; go to IDLE.
- Latency:
  - command pushed at edge E0 into an idle block: popped at E1, rast_start high in the cycle after E1.
  - back-to-back commands: 3 cycles of overhead (RETIRE, IDLE, START) between rast_done and the next rast_start.
- rast_vtx and rast_color stay stable from the pop until the next pop.
- Pixel path:
  - when state is START or WAIT and rast_pixel_valid = 1, register fb_x/fb_y/fb_color from rast_* and assert fb_we on the next cycle (1-cycle latency).
  - pixel_count increments by one per write, saturating at all-ones.
  - rast_pixel_valid in IDLE or RETIRE is dropped.
  - rast_pixel_valid together with rast_done in WAIT: the pixel is forwarded and counted.
- No backpressure toward the rasterizer; the framebuffer must accept one write per cycle.

Optional Feature:
- FB_CLIP_EN defined:
  - pixels with rast_px >= SCREEN_W or rast_py >= SCREEN_H do not raise fb_we and are not counted.
  - fb_x/fb_y/fb_color may still update.
- FB_CLIP_EN undefined: every accepted pixel is written; SCREEN_W/SCREEN_H have no effect.

Test Plan:
- Port 0 pushes (10,5),(50,20),(20,40), colour FF0000, while idle:
  - rast_start is a single pulse in the 2nd cycle after the push, with rast_vtx matching.
  - each pixel_valid is mirrored on fb_we one cycle later.
  - cmd_done fires with done_src = 0 and pixel_count equal to the number of strobes.
- Ports 0 and 1 each push two commands in the same cycles -> rasterizer start order is port 0, 1, 0, 1; done_src follows the same order.
- Port 1 pushes while one command is held in WAIT (rast_done low) -> req1_ready drops after the 4th queued entry; the 5th command is accepted only after the next pop.
- rst_n asserted mid-WAIT with 2 commands queued -> fb_we, busy and rast_start go to 0 immediately. After release, a new port 0 command is started normally and none of the discarded commands are started.
- rast_done and the last rast_pixel_valid in the same cycle -> the last pixel is written and counted; cmd_done follows one cycle after WAIT exits.
- FB_CLIP_EN on, pixels at (170,10) and (20,10) -> only (20,10) is written; pixel_count = 1.

Source files
------------

// File: rtl/tri_draw_scheduler.sv
// Two-port triangle draw scheduler: per-port command FIFOs, round-robin grant,
// rasterizer sequencing and pixel forwarding. Define FB_CLIP_EN to drop off-screen pixels.

module tds_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 72
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] din_i,
  output logic [W-1:0] dout_o,
  output logic         empty_o,
  output logic         full_o
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_q, wr_d, rd_q, rd_d;
  logic         full_q, full_d;
  logic [W-1:0] mem_q [DEPTH];

  assign wr_d    = wr_q + {{AW{1'b0}}, push_i};
  assign rd_d    = rd_q + {{AW{1'b0}}, pop_i};
  assign full_d  = (wr_d[AW] != rd_d[AW]) && (wr_d[AW-1:0] == rd_d[AW-1:0]);
  assign empty_o = (wr_q == rd_q);
  assign full_o  = full_q;
  assign dout_o  = mem_q[rd_q[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q   <= '0;
      rd_q   <= '0;
      full_q <= 1'b0;
    end else begin
      wr_q   <= wr_d;
      rd_q   <= rd_d;
      full_q <= full_d;
    end
  end

  always_ff @(posedge clk)
    if (push_i) mem_q[wr_q[AW-1:0]] <= din_i;
endmodule

module tri_draw_scheduler #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16,
  parameter int SCREEN_W   = 160,
  parameter int SCREEN_H   = 120
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [71:0]      req0_cmd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [71:0]      req1_cmd,
  output logic             rast_start,
  output logic [47:0]      rast_vtx,
  output logic [23:0]      rast_color,
  input  logic             rast_pixel_valid,
  input  logic [7:0]       rast_px,
  input  logic [7:0]       rast_py,
  input  logic [23:0]      rast_pixel_color,
  input  logic             rast_done,
  output logic             fb_we,
  output logic [7:0]       fb_x,
  output logic [7:0]       fb_y,
  output logic [23:0]      fb_color,
  output logic             busy,
  output logic             cur_src,
  output logic             cmd_done,
  output logic             done_src,
  output logic [CNT_W-1:0] pixel_count
);
  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RETIRE} state_t;

  state_t            state_q, state_d;
  logic              rr_q, rr_d, src_q, src_d;
  logic [47:0]       vtx_q, vtx_d;
  logic [23:0]       col_q, col_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              fb_we_q, fb_we_d;
  logic [7:0]        fbx_q, fbx_d, fby_q, fby_d;
  logic [23:0]       fbc_q, fbc_d;

  logic [1:0]        req_valid, push, pop, empty, full, ne;
  logic [1:0][71:0]  req_cmd, fifo_dout;
  logic              gnt, pix_acc, pix_ok, pix_wr;

  assign req_valid = {req1_valid, req0_valid};
  assign req_cmd   = {req1_cmd, req0_cmd};
  assign push      = req_valid & ~full;
  assign ne        = ~empty;

  for (genvar g = 0; g < 2; g++) begin : g_port
    tds_fifo #(.DEPTH(FIFO_DEPTH), .W(72)) u_fifo (
      .clk(clk), .rst_n(rst_n), .push_i(push[g]), .pop_i(pop[g]),
      .din_i(req_cmd[g]), .dout_o(fifo_dout[g]), .empty_o(empty[g]), .full_o(full[g])
    );
  end

  // Pointer only breaks ties; a lone non-empty port always wins.
  assign gnt = (ne[0] & ne[1]) ? rr_q : ne[1];

`ifdef FB_CLIP_EN
  assign pix_ok = (32'(rast_px) < SCREEN_W) && (32'(rast_py) < SCREEN_H);
`else
  assign pix_ok = 1'b1;
`endif

  assign pix_acc = rast_pixel_valid && (state_q == S_START || state_q == S_WAIT);
  assign pix_wr  = pix_acc && pix_ok;

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    src_d   = src_q;
    vtx_d   = vtx_q;
    col_d   = col_q;
    cnt_d   = cnt_q;
    pop     = '0;
    fb_we_d = pix_wr;
    fbx_d   = fbx_q;
    fby_d   = fby_q;
    fbc_d   = fbc_q;
    if (pix_acc) begin
      fbx_d = rast_px;
      fby_d = rast_py;
      fbc_d = rast_pixel_color;
    end
    if (pix_wr && cnt_q != '1) cnt_d = cnt_q + 1'b1;
    case (state_q)
      S_IDLE: if (|ne) begin
        pop[gnt] = 1'b1;
        src_d    = gnt;
        vtx_d    = fifo_dout[gnt][47:0];
        col_d    = fifo_dout[gnt][71:48];
        cnt_d    = '0;
        rr_d     = ~gnt;
        state_d  = S_START;
      end
      S_START:  state_d = S_WAIT;
      S_WAIT:   if (rast_done) state_d = S_RETIRE;
      S_RETIRE: state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      rr_q    <= 1'b0;
      src_q   <= 1'b0;
      vtx_q   <= '0;
      col_q   <= '0;
      cnt_q   <= '0;
      fb_we_q <= 1'b0;
      fbx_q   <= '0;
      fby_q   <= '0;
      fbc_q   <= '0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      src_q   <= src_d;
      vtx_q   <= vtx_d;
      col_q   <= col_d;
      cnt_q   <= cnt_d;
      fb_we_q <= fb_we_d;
      fbx_q   <= fbx_d;
      fby_q   <= fby_d;
      fbc_q   <= fbc_d;
    end
  end

  assign req0_ready  = ~full[0];
  assign req1_ready  = ~full[1];
  assign rast_start  = (state_q == S_START);
  assign rast_vtx    = vtx_q;
  assign rast_color  = col_q;
  assign fb_we       = fb_we_q;
  assign fb_x        = fbx_q;
  assign fb_y        = fby_q;
  assign fb_color    = fbc_q;
  assign busy        = (state_q != S_IDLE);
  assign cur_src     = src_q;
  assign cmd_done    = (state_q == S_RETIRE);
  assign done_src    = (state_q == S_RETIRE) & src_q;
  assign pixel_count = cnt_q;
endmodule

// File: tb/tb_tri_draw_scheduler.sv
// Scoreboard bench for tri_draw_scheduler: directed steps drive commands and a
// rasterizer model; a negedge monitor pops expected starts, pixel writes and retirements.

module tb_tri_draw_scheduler;
  localparam int CW = 3;
`ifdef FB_CLIP_EN
  localparam bit CLIP = 1'b1;
`else
  localparam bit CLIP = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, req0_valid, req0_ready, req1_valid, req1_ready, rast_start;
  logic [71:0] req0_cmd, req1_cmd;
  logic [47:0] rast_vtx;
  logic [23:0] rast_color, rast_pixel_color, fb_color;
  logic rast_pixel_valid, rast_done, fb_we, busy, cur_src, cmd_done, done_src;
  logic [7:0] rast_px, rast_py, fb_x, fb_y;
  logic [CW-1:0] pixel_count;

  tri_draw_scheduler #(.FIFO_DEPTH(4), .CNT_W(CW), .SCREEN_W(160), .SCREEN_H(120)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_cmd(req0_cmd),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_cmd(req1_cmd),
    .rast_start(rast_start), .rast_vtx(rast_vtx), .rast_color(rast_color),
    .rast_pixel_valid(rast_pixel_valid), .rast_px(rast_px), .rast_py(rast_py),
    .rast_pixel_color(rast_pixel_color), .rast_done(rast_done),
    .fb_we(fb_we), .fb_x(fb_x), .fb_y(fb_y), .fb_color(fb_color),
    .busy(busy), .cur_src(cur_src), .cmd_done(cmd_done), .done_src(done_src),
    .pixel_count(pixel_count)
  );

  logic [71:0]   pq0[$], pq1[$];
  logic          ord_q[$];
  logic [39:0]   fb_q[$];
  logic [CW:0]   ret_q[$];
  int n_cmp = 0, n_err = 0;
  int starts_seen = 0, dones_seen = 0, fb_seen = 0;
  int ord_tot = 0, ret_tot = 0, fb_tot = 0;
  logic [CW-1:0] cnt_m;

  task automatic chk(input string tag, input logic [79:0] obs, input logic [79:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [71:0] mk(input logic [23:0] c, input logic [7:0] x0, y0, x1, y1, x2, y2);
    return {c, y2, x2, y1, x1, y0, x0};
  endfunction

  logic [71:0] m_c;
  logic        m_s;
  logic [39:0] m_f;
  logic [CW:0] m_r;
  always @(negedge clk) if (rst_n) begin
    if (rast_start) begin
      starts_seen++;
      chk("start_expected", 80'(ord_q.size() != 0), 1);
      if (ord_q.size() != 0) begin
        m_s = ord_q.pop_front();
        chk("start_src", cur_src, m_s);
        chk("cmd_queued", 80'(m_s ? pq1.size() != 0 : pq0.size() != 0), 1);
        if ((m_s ? pq1.size() : pq0.size()) != 0) begin
          m_c = m_s ? pq1.pop_front() : pq0.pop_front();
          chk("rast_vtx", rast_vtx, m_c[47:0]);
          chk("rast_color", rast_color, m_c[71:48]);
        end
        chk("cnt_cleared", pixel_count, 0);
      end
    end
    if (fb_we) begin
      fb_seen++;
      chk("fb_expected", 80'(fb_q.size() != 0), 1);
      if (fb_q.size() != 0) begin
        m_f = fb_q.pop_front();
        chk("fb_write", {fb_x, fb_y, fb_color}, m_f);
      end
    end
    if (cmd_done) begin
      dones_seen++;
      chk("done_expected", 80'(ret_q.size() != 0), 1);
      if (ret_q.size() != 0) begin
        m_r = ret_q.pop_front();
        chk("done_src_cnt", {done_src, pixel_count}, m_r);
      end
    end
  end

  task automatic exp_src(input logic s);
    ord_q.push_back(s);
    ord_tot++;
  endtask

  task automatic push(input logic p, input logic [71:0] c);
    int k = 0;
    while (!(p ? req1_ready : req0_ready) && k < 50) begin @(negedge clk); k++; end
    chk("push_ready", p ? req1_ready : req0_ready, 1);
    if (p) begin req1_valid = 1'b1; req1_cmd = c; pq1.push_back(c); end
    else   begin req0_valid = 1'b1; req0_cmd = c; pq0.push_back(c); end
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic push2(input logic [71:0] c0, input logic [71:0] c1);
    chk("push2_ready", {req1_ready, req0_ready}, 2'b11);
    req0_valid = 1'b1; req0_cmd = c0; pq0.push_back(c0);
    req1_valid = 1'b1; req1_cmd = c1; pq1.push_back(c1);
    @(negedge clk);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic wait_start();
    int k = 0;
    while (!rast_start && k < 50) begin @(negedge clk); k++; end
    chk("start_seen", rast_start, 1);
    rast_done = 1'b0;
    cnt_m = '0;
  endtask

  task automatic pix(input logic [7:0] x, input logic [7:0] y, input logic [23:0] c,
                     input bit dn, input logic src);
    rast_pixel_valid = 1'b1; rast_px = x; rast_py = y; rast_pixel_color = c; rast_done = dn;
    if (!CLIP || (x < 8'd160 && y < 8'd120)) begin
      fb_q.push_back({x, y, c});
      fb_tot++;
      if (cnt_m != {CW{1'b1}}) cnt_m++;
    end
    if (dn) begin ret_q.push_back({src, cnt_m}); ret_tot++; end
    @(negedge clk);
    rast_pixel_valid = 1'b0;
  endtask

  task automatic done_cmd(input logic src);
    rast_done = 1'b1;
    ret_q.push_back({src, cnt_m});
    ret_tot++;
    @(negedge clk);
  endtask

  task automatic run_cmd(input logic src, input int n);
    wait_start();
    for (int i = 0; i < n; i++)
      pix(8'(i * 7 + 1), 8'(i + 2), 24'(i * 32'h10203 + 5), 1'b0, src);
    done_cmd(src);
  endtask

  initial begin
    rst_n = 1'b0; req0_valid = 0; req1_valid = 0; req0_cmd = '0; req1_cmd = '0;
    rast_pixel_valid = 0; rast_px = 0; rast_py = 0; rast_pixel_color = 0; rast_done = 0;
    cnt_m = '0;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_ready", {req1_ready, req0_ready}, 2'b11);
    chk("rst_outs", {fb_we, rast_start, cmd_done, done_src, cur_src}, 0);
    chk("rst_cnt_vtx", {pixel_count, rast_vtx, rast_color}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin: both ports push two commands in the same cycles
    exp_src(0); exp_src(1); exp_src(0); exp_src(1);
    push2(mk(24'h0000AA, 1, 2, 3, 4, 5, 6), mk(24'h0000BB, 11, 12, 13, 14, 15, 16));
    push2(mk(24'h0000CC, 21, 22, 23, 24, 25, 26), mk(24'h0000DD, 31, 32, 33, 34, 35, 36));
    run_cmd(0, 1);
    run_cmd(1, 2);
    run_cmd(0, 0);
    run_cmd(1, 9);
    repeat (2) @(negedge clk);

    // Single command into an idle block: start latency, pixel mirroring
    exp_src(0);
    push(0, mk(24'hFF0000, 10, 5, 50, 20, 20, 40));
    chk("t1_no_early_start", rast_start, 0);
    @(negedge clk);
    chk("t1_start", rast_start, 1);
    rast_done = 1'b0; cnt_m = '0;
    pix(8'd12, 8'd8, 24'hFF0000, 1'b0, 0);
    chk("t1_fb_lat", fb_we, 1);
    chk("t1_single_pulse", rast_start, 0);
    pix(8'd13, 8'd8, 24'hFF0000, 1'b0, 0);
    chk("t1_fb_lat2", fb_we, 1);
    pix(8'd14, 8'd9, 24'hFF0000, 1'b0, 0);
    done_cmd(0);
    repeat (2) @(negedge clk);

    // FIFO full on port 1 while port 0 command is held in WAIT
    exp_src(0);
    for (int i = 0; i < 5; i++) exp_src(1);
    push(0, mk(24'h123456, 9, 9, 9, 9, 9, 9));
    wait_start();
    pix(8'd3, 8'd3, 24'h123456, 1'b0, 0);
    for (int i = 0; i < 4; i++) push(1, mk(24'(32'hB00 + i), 8'(i), 1, 2, 3, 4, 5));
    chk("t3_full", req1_ready, 0);
    req1_valid = 1'b1; req1_cmd = mk(24'hB05, 5, 5, 5, 5, 5, 5);
    repeat (3) begin @(negedge clk); chk("t3_held", req1_ready, 0); end
    done_cmd(0);
    chk("t3_retire_full", req1_ready, 0);
    @(negedge clk);
    chk("t3_idle_full", req1_ready, 0);
    @(negedge clk);
    chk("t3_after_pop", {req1_ready, rast_start}, 2'b11);
    pq1.push_back(req1_cmd);
    rast_done = 1'b0; cnt_m = '0;
    pix(8'd4, 8'd4, 24'h0B0B0B, 1'b0, 1);
    req1_valid = 1'b0;
    done_cmd(1);
    for (int i = 0; i < 4; i++) run_cmd(1, i);
    repeat (2) @(negedge clk);

    // Reset mid-WAIT with two commands queued
    exp_src(0);
    push(0, mk(24'hDEAD00, 7, 7, 7, 7, 7, 7));
    wait_start();
    push(1, mk(24'h111111, 1, 1, 1, 1, 1, 1));
    push(0, mk(24'h222222, 2, 2, 2, 2, 2, 2));
    rast_pixel_valid = 1'b1; rast_px = 8'd1; rast_py = 8'd1; rast_pixel_color = 24'h1;
    @(posedge clk); #1;
    chk("t4_fb_pre", fb_we, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("t4_rst_immediate", {fb_we, busy, rast_start}, 0);
    rast_pixel_valid = 1'b0;
    pq0.delete(); pq1.delete(); fb_q.delete(); ret_q.delete(); ord_q.delete();
    @(negedge clk);
    rast_done = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t4_post_rst", {busy, req1_ready, req0_ready}, 3'b011);
    exp_src(0);
    push(0, mk(24'h00FF00, 40, 41, 42, 43, 44, 45));
    run_cmd(0, 2);
    repeat (8) @(negedge clk);

    // Last pixel coincides with rast_done
    exp_src(0);
    push(0, mk(24'h0000FF, 60, 61, 62, 63, 64, 65));
    wait_start();
    pix(8'd30, 8'd31, 24'hABCDEF, 1'b0, 0);
    pix(8'd32, 8'd33, 24'hFEDCBA, 1'b1, 0);
    chk("t5_done_next", cmd_done, 1);
    @(negedge clk);
    chk("t5_done_pulse", cmd_done, 0);
    @(negedge clk);

    // Off-screen pixel (dropped only when clipping is built in)
    exp_src(1);
    push(1, mk(24'h777777, 70, 71, 72, 73, 74, 75));
    wait_start();
    pix(8'd170, 8'd10, 24'h000170, 1'b0, 1);
    pix(8'd20, 8'd10, 24'h000020, 1'b0, 1);
    done_cmd(1);
    repeat (3) @(negedge clk);

    // Pixel strobe while idle must be dropped
    rast_pixel_valid = 1'b1; rast_px = 8'd5; rast_py = 8'd5; rast_pixel_color = 24'h5;
    @(negedge clk);
    rast_pixel_valid = 1'b0;
    repeat (6) @(negedge clk);

    chk("tot_starts", 80'(starts_seen), 80'(ord_tot));
    chk("tot_dones", 80'(dones_seen), 80'(ret_tot));
    chk("tot_fb", 80'(fb_seen), 80'(fb_tot));
    chk("queues_drained", 80'(pq0.size() + pq1.size() + fb_q.size() + ret_q.size() + ord_q.size()), 0);
    chk("final_idle", {busy, req1_ready, req0_ready}, 3'b011);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
